// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with a double-buffered output.
// Bits arrive on sin (qualified by svalid). frame marks the first bit of a word,
// and dir, sampled on that first bit, selects LSB-first (0) or MSB-first (1) order.
// A completed word moves into the output holding register and is offered on a
// valid/ready interface. The next word can shift in while the current one waits.
// Optional build macro: SERIAL_RX_PARITY_EN adds a trailing even-parity bit per word.
module serial_word_receiver #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sin,
  input  logic             svalid,
  input  logic             frame,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err,
  output logic             par_err
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StParity
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;

  // Decoded per-cycle events
  logic             restart;      // frame bit accepted: start (or restart) a word
  logic             mid_frame;    // frame bit arrived while a word was in progress
  logic             data_bit;     // ordinary data bit shifted into the current word
  logic             last_data;    // data_bit that is the WIDTH-th bit of the word
  logic             word_done;    // a complete, good word is ready for transfer
  logic [WIDTH-1:0] word;         // the word offered for transfer
  logic [WIDTH-1:0] sh_shifted;   // shift register after accepting sin

`ifdef SERIAL_RX_PARITY_EN
  logic parity_bit;
  logic parity_ok;
  logic par_err_q, par_err_d;
`endif

  // dir=0 fills from the top (LSB first), dir=1 fills from the bottom (MSB first).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                input logic             d,
                                                input logic             b);
    if (d) begin
      return {base[WIDTH-2:0], b};
    end
    return {b, base[WIDTH-1:1]};
  endfunction

  // Decode which event the current serial beat represents.
  always_comb begin
    restart    = svalid && frame;
    mid_frame  = restart && (state_q != StIdle);
    data_bit   = svalid && !frame && (state_q == StShift);
    last_data  = data_bit && (cnt_q == CntW'(WIDTH - 1));
    sh_shifted = shift_in(sh_q, dir_q, sin);
`ifdef SERIAL_RX_PARITY_EN
    parity_bit = svalid && !frame && (state_q == StParity);
    // Even parity: data bits plus the parity bit must XOR to zero.
    parity_ok  = ((^sh_q) ^ sin) == 1'b0;
    word_done  = parity_bit && parity_ok;
    word       = sh_q;
`else
    word_done  = last_data;
    word       = sh_shifted;
`endif
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (restart) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (restart) begin
          state_d = StShift;
        end else if (last_data) begin
`ifdef SERIAL_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StIdle;
`endif
        end
      end
      StParity: begin
`ifdef SERIAL_RX_PARITY_EN
        if (restart) begin
          state_d = StShift;
        end else if (parity_bit) begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift register, bit counter and latched bit order.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (restart) begin
      // The partial word (if any) is discarded; this bit becomes bit 0.
      sh_d  = shift_in('0, dir, sin);
      cnt_d = CntW'(1);
      dir_d = dir;
    end else if (data_bit) begin
      sh_d  = sh_shifted;
      cnt_d = last_data ? '0 : cnt_q + 1'b1;
    end
  end

  // Output holding register, handshake and sticky error flags.
  always_comb begin
    out_d       = out_q;
    // An accepted word drops valid unless a new word is loaded this same edge.
    out_valid_d = out_valid_q && !out_ready;
    // Clear first so that a coinciding set event wins.
    overrun_d   = overrun_q && !clr_err;
    frame_err_d = frame_err_q && !clr_err;
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_d       = word;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (mid_frame) begin
      frame_err_d = 1'b1;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Sticky parity error; a bad word never touches the output register.
  always_comb begin
    par_err_d = par_err_q && !clr_err;
    if (parity_bit && !parity_ok) begin
      par_err_d = 1'b1;
    end
  end

  // Parity error flag register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end
`endif

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Drive module outputs from state.
  always_comb begin
    out       = out_q;
    out_valid = out_valid_q;
    busy      = (state_q != StIdle);
    overrun   = overrun_q;
    frame_err = frame_err_q;
`ifdef SERIAL_RX_PARITY_EN
    par_err   = par_err_q;
`else
    par_err   = 1'b0;
`endif
  end

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Serial-to-parallel receiver for words shifted out serially by a universal shift register (right shift = LSB first, left shift = MSB first).
- Assembles WIDTH bits into a word and presents it on a valid/ready output interface.
- Double-buffered: a shift register plus an output holding register, so the next word can be received while the current word waits for acceptance.
- Sits between a serial link and the 16-bit datapath register file / bus.

Parameters:
- WIDTH, 16, number of data bits per word (2..31).

Ports:
- CLOCK  input  1  system clock; all state updates on posedge.
- RESET_N  input  1  asynchronous active-low reset.
- SIN  input  1  serial data bit.
- SVALID  input  1  SIN carries a valid bit this cycle.
- FRAME  input  1  start-of-word marker; qualified by SVALID; marks the first bit of a word.
- DIR  input  1  bit order: 0 = LSB first (right shift), 1 = MSB first (left shift); sampled only on the first bit.
- OUT  output  WIDTH  received word (output holding register).
- OUT_VALID  output  1  OUT holds an unaccepted word.
- OUT_READY  input  1  consumer accepts OUT when OUT_VALID=1.
- BUSY  output  1  a word is partially received.
- OVERRUN  output  1  sticky: a completed word was dropped.
- FRAME_ERR  output  1  sticky: FRAME arrived mid-word.
- CLR_ERR  input  1  synchronous clear of the sticky flags.
- PAR_ERR  output  1  sticky parity error; tied 0 when the parity feature is disabled.

Behaviour:
- Reset (async, RESET_N=0):
  - OUT=0, OUT_VALID=0, BUSY=0, OVERRUN=0, FRAME_ERR=0, PAR_ERR=0.
  - Shift register=0, bit counter=0, FSM=IDLE.
- FSM states: IDLE, SHIFT (plus PARITY when the feature is enabled).
- IDLE:
  - SVALID=1 and FRAME=1: latch DIR, shift in SIN, count=1, go to SHIFT.
  - SVALID=1 and FRAME=0: bit ignored, no flag set.
- Shift rule on each accepted bit:
  - DIR=0: sh={SIN, sh[WIDTH-1:1]}.
  - DIR=1: sh={sh[WIDTH-2:0], SIN}.
- SHIFT:
  - Each SVALID=1 cycle shifts one bit and increments count.
  - SVALID=0: hold; no timeout.
- FRAME=1 with SVALID=1 while in SHIFT:
  - Discard the partial word and set FRAME_ERR.
  - Restart with this bit as bit 0 (count=1, DIR re-latched).
- Word completion, on the cycle the WIDTH-th bit is shifted; transfer happens at that same clock edge, so latency from last bit to OUT_VALID=1 is 1 cycle:
  - OUT_VALID=0: OUT<=assembled word, OUT_VALID<=1.
  - OUT_VALID=1 and OUT_READY=1 in the same cycle: old word accepted, new word loaded, OUT_VALID stays 1, no overrun.
  - OUT_VALID=1 and OUT_READY=0: new word dropped, OUT unchanged, OVERRUN<=1.
  - FSM returns to IDLE and count=0.
  - A FRAME bit in the very next cycle is accepted (back-to-back words, zero gap).
- Handshake:
  - OUT_VALID falls the cycle after OUT_VALID&&OUT_READY, unless reloaded per the completion rule above.
  - OUT is stable while OUT_VALID=1.
- BUSY=1 exactly when FSM≠IDLE.
- Flags:
  - CLR_ERR=1 clears OVERRUN, FRAME_ERR and PAR_ERR next edge.
  - If a set event coincides with CLR_ERR, the set wins.
- RESET_N asserted mid-word: partial word and OUT are lost immediately (asynchronous).

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY and consumes one more SVALID bit as an even-parity bit (XOR of data plus parity must be 0).
  - Match: completion rules apply on the parity-bit cycle.
  - Mismatch: word discarded, PAR_ERR<=1, OUT/OUT_VALID unchanged, return to IDLE.
  - FRAME during PARITY is treated as mid-word (FRAME_ERR, restart).
- Undefined:
  - No PARITY state; completion occurs on the WIDTH-th bit.
  - PAR_ERR is constant 0.

Test Plan:
- Reset, then DIR=0, FRAME on first bit, send 0xA5C3 LSB first, one bit per cycle, OUT_READY=0 -> OUT=0xA5C3 and OUT_VALID=1 one cycle after the 16th bit; BUSY high for bits 1..15.
- DIR=1, send 0x1234 MSB first with SVALID gaps every 3rd cycle -> OUT=0x1234; gaps do not corrupt data.
- Word 0x00FF pending (OUT_READY=0), second word 0xFF00 completes -> OUT stays 0x00FF, OVERRUN=1; CLR_ERR pulse -> OVERRUN=0. Repeat with OUT_READY=1 on the completion cycle -> OUT=0xFF00, OVERRUN=0.
- FRAME re-asserted after 7 bits, then 16 bits of 0xBEEF -> FRAME_ERR=1, OUT=0xBEEF.
- RESET_N pulsed low after 9 bits, then a full word 0x0F0F -> all outputs 0 during reset; afterwards OUT=0x0F0F with no stale bits.
- With SERIAL_RX_PARITY_EN: 0x0001 with parity bit 1 -> OUT=0x0001; same word with parity bit 0 -> PAR_ERR=1, OUT_VALID unchanged.
